reorder_buffer: RTL and testbench

//  In-order reorder buffer (ROB) beside the register map table. Allocates one ROB tag per dispatched instruction.

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer_ptr_ctr.sv | 16 +
 rtl/reorder_buffer.sv | 97 +++++++++
 tb/tb_reorder_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, depth/no-tag constants and the ROB entry layout for the reorder buffer.
package reorder_buffer_pkg;
   localparam int ROB_TAG_LEN  = 3;
   localparam int REG_ADDR_LEN = 5;
   localparam int XLEN         = 32;

   // All-ones tag means "no tag", so one tag value is never allocated.
   localparam int DEPTH = 2**ROB_TAG_LEN - 1;
   localparam logic [ROB_TAG_LEN-1:0] NO_TAG   = '1;
   localparam logic [ROB_TAG_LEN-1:0] LAST_TAG = ROB_TAG_LEN'(DEPTH - 1);
   localparam logic [ROB_TAG_LEN-1:0] FULL_CNT = ROB_TAG_LEN'(DEPTH);

   typedef struct packed {
      logic                    valid;
      logic                    ready;
      logic [REG_ADDR_LEN-1:0] dest;
      logic [XLEN-1:0]         value;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_ptr_ctr.sv
// Wrapping ROB pointer 0..DEPTH-1 with increment enable; used for both head and tail.
module reorder_buffer_ptr_ctr
   import reorder_buffer_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inc,
   output logic [ROB_TAG_LEN-1:0] ptr
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (inc)
         ptr <= (ptr == LAST_TAG) ? '0 : ptr + 1'b1;
   end
endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tag allocation, CDB capture, operand reads and head retirement.
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB value onto the operand read ports.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dispatch_valid,
   input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
   output logic                    dispatch_ready,
   output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
   input  logic                    cdb_valid,
   input  logic [ROB_TAG_LEN-1:0]  cdb_rob_tag,
   input  logic [XLEN-1:0]         cdb_value,
   input  logic [ROB_TAG_LEN-1:0]  rd1_tag,
   input  logic [ROB_TAG_LEN-1:0]  rd2_tag,
   output logic [XLEN-1:0]         rd1_value,
   output logic [XLEN-1:0]         rd2_value,
   output logic                    commit_valid,
   output logic [REG_ADDR_LEN-1:0] commit_reg_addr,
   output logic [ROB_TAG_LEN-1:0]  commit_rob_tag,
   output logic [XLEN-1:0]         commit_value,
   output logic                    empty,
   output logic                    full,
   output logic [ROB_TAG_LEN-1:0]  count
);
   rob_entry_t             entries [DEPTH];
   logic [ROB_TAG_LEN-1:0] head;
   logic [ROB_TAG_LEN-1:0] tail;
   logic                   alloc;
   logic                   cdb_hit;

   assign empty          = (count == '0);
   assign full           = (count == FULL_CNT);
   assign dispatch_ready = !full;
   assign alloc          = dispatch_valid && !full;
   assign assign_rob_tag = tail;
   assign cdb_hit        = cdb_valid && (cdb_rob_tag != NO_TAG) && entries[cdb_rob_tag].valid;

   assign commit_valid    = entries[head].valid && entries[head].ready;
   assign commit_reg_addr = entries[head].dest;
   assign commit_rob_tag  = head;
   assign commit_value    = entries[head].value;

   reorder_buffer_ptr_ctr u_head (.clk(clk), .reset(reset), .inc(commit_valid), .ptr(head));
   reorder_buffer_ptr_ctr u_tail (.clk(clk), .reset(reset), .inc(alloc),        .ptr(tail));

   // Commit is written after the CDB capture so retirement always wins on the head entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            entries[i] <= '0;
      end else begin
         if (cdb_hit) begin
            entries[cdb_rob_tag].ready <= 1'b1;
            entries[cdb_rob_tag].value <= cdb_value;
         end
         if (commit_valid) begin
            entries[head].valid <= 1'b0;
            entries[head].ready <= 1'b0;
         end
         if (alloc)
            entries[tail] <= '{valid: 1'b1, ready: 1'b0, dest: dispatch_dest, value: '0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (alloc && !commit_valid)
         count <= count + 1'b1;
      else if (!alloc && commit_valid)
         count <= count - 1'b1;
   end

   always_comb begin
      rd1_value = '0;
      if (rd1_tag != NO_TAG && entries[rd1_tag].valid) begin
         rd1_value = entries[rd1_tag].value;
`ifdef ROB_CDB_BYPASS_EN
         if (cdb_valid && cdb_rob_tag == rd1_tag)
            rd1_value = cdb_value;
`endif
      end
   end

   always_comb begin
      rd2_value = '0;
      if (rd2_tag != NO_TAG && entries[rd2_tag].valid) begin
         rd2_value = entries[rd2_tag].value;
`ifdef ROB_CDB_BYPASS_EN
         if (cdb_valid && cdb_rob_tag == rd2_tag)
            rd2_value = cdb_value;
`endif
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; inputs change on the falling edge, checks #1 later.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    dispatch_valid = 1'b0;
   logic [REG_ADDR_LEN-1:0] dispatch_dest = '0;
   logic                    dispatch_ready;
   logic [ROB_TAG_LEN-1:0]  assign_rob_tag;
   logic                    cdb_valid = 1'b0;
   logic [ROB_TAG_LEN-1:0]  cdb_rob_tag = '0;
   logic [XLEN-1:0]         cdb_value = '0;
   logic [ROB_TAG_LEN-1:0]  rd1_tag = '1;
   logic [ROB_TAG_LEN-1:0]  rd2_tag = '1;
   logic [XLEN-1:0]         rd1_value;
   logic [XLEN-1:0]         rd2_value;
   logic                    commit_valid;
   logic [REG_ADDR_LEN-1:0] commit_reg_addr;
   logic [ROB_TAG_LEN-1:0]  commit_rob_tag;
   logic [XLEN-1:0]         commit_value;
   logic                    empty;
   logic                    full;
   logic [ROB_TAG_LEN-1:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest),
      .dispatch_ready(dispatch_ready), .assign_rob_tag(assign_rob_tag),
      .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_value(cdb_value),
      .rd1_tag(rd1_tag), .rd2_tag(rd2_tag), .rd1_value(rd1_value), .rd2_value(rd2_value),
      .commit_valid(commit_valid), .commit_reg_addr(commit_reg_addr),
      .commit_rob_tag(commit_rob_tag), .commit_value(commit_value),
      .empty(empty), .full(full), .count(count)
   );

   // Move to the next falling edge with all inputs idle.
   task automatic idle_cycle();
      @(negedge clk);
      dispatch_valid = 1'b0;
      cdb_valid      = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      dispatch_valid = 1'b0;
      cdb_valid      = 1'b0;
      rd1_tag        = '1;
      rd2_tag        = '1;
      reset          = 1'b1;
      #2;
      reset          = 1'b0;
   endtask

   task automatic dispatch_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cdb_valid      = 1'b0;
         dispatch_valid = 1'b1;
         dispatch_dest  = REG_ADDR_LEN'(i + 10);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_cmp++; if (assign_rob_tag !== 3'd0) begin n_err++; $display("FAIL reset_tag got=%0d exp=0", assign_rob_tag); end
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
      n_cmp++; if (dispatch_ready !== 1'b1) begin n_err++; $display("FAIL reset_dispatch_ready got=%0b exp=1", dispatch_ready); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%0b exp=0", full); end
   endtask

   task automatic test_commit_order();
      logic [REG_ADDR_LEN-1:0] dests [3];
      dests[0] = 5'd5; dests[1] = 5'd7; dests[2] = 5'd9;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dispatch_valid = 1'b1;
         dispatch_dest  = dests[i];
         #1;
         n_cmp++; if (assign_rob_tag !== 3'(i)) begin n_err++; $display("FAIL order_alloc_tag%0d got=%0d exp=%0d", i, assign_rob_tag, i); end
      end
      @(negedge clk);
      dispatch_valid = 1'b0;
      cdb_valid = 1'b1; cdb_rob_tag = 3'd1; cdb_value = 32'hAA;
      #1;
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL order_count got=%0d exp=3", count); end
      @(negedge clk);
      cdb_rob_tag = 3'd0; cdb_value = 32'h55;
      #1;
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL order_no_early_commit got=%0b exp=0", commit_valid); end
      idle_cycle();
      n_cmp++; if (commit_valid !== 1'b1 || commit_reg_addr !== 5'd5 || commit_value !== 32'h55 || commit_rob_tag !== 3'd0)
         begin n_err++; $display("FAIL order_commit0 got=%0b/r%0d/%h/t%0d exp=1/r5/55/t0", commit_valid, commit_reg_addr, commit_value, commit_rob_tag); end
      idle_cycle();
      n_cmp++; if (commit_valid !== 1'b1 || commit_reg_addr !== 5'd7 || commit_value !== 32'hAA || commit_rob_tag !== 3'd1)
         begin n_err++; $display("FAIL order_commit1 got=%0b/r%0d/%h/t%0d exp=1/r7/aa/t1", commit_valid, commit_reg_addr, commit_value, commit_rob_tag); end
      idle_cycle();
      n_cmp++; if (commit_valid !== 1'b0 || commit_rob_tag !== 3'd2 || count !== 3'd1)
         begin n_err++; $display("FAIL order_head_hold got=%0b/t%0d/c%0d exp=0/t2/c1", commit_valid, commit_rob_tag, count); end
   endtask

   task automatic test_full();
      do_reset();
      dispatch_n(7);
      @(negedge clk);
      dispatch_dest = 5'd3;
      #1;
      n_cmp++; if (full !== 1'b1 || dispatch_ready !== 1'b0 || count !== 3'd7)
         begin n_err++; $display("FAIL full_flags got=f%0b/r%0b/c%0d exp=f1/r0/c7", full, dispatch_ready, count); end
      @(negedge clk);
      cdb_valid = 1'b1; cdb_rob_tag = 3'd0; cdb_value = 32'h0BAD;
      #1;
      n_cmp++; if (count !== 3'd7 || assign_rob_tag !== 3'd0 || commit_rob_tag !== 3'd0)
         begin n_err++; $display("FAIL full_drop got=c%0d/t%0d/h%0d exp=c7/t0/h0", count, assign_rob_tag, commit_rob_tag); end
      @(negedge clk);
      cdb_valid = 1'b0;
      #1;
      n_cmp++; if (commit_valid !== 1'b1 || commit_value !== 32'h0BAD || commit_reg_addr !== 5'd10)
         begin n_err++; $display("FAIL full_commit_ready got=%0b/%h/r%0d exp=1/bad/r10", commit_valid, commit_value, commit_reg_addr); end
      @(negedge clk);
      #1;
      n_cmp++; if (count !== 3'd6 || full !== 1'b0 || dispatch_ready !== 1'b1 || assign_rob_tag !== 3'd0)
         begin n_err++; $display("FAIL full_no_room_same_cycle got=c%0d/f%0b/r%0b/t%0d exp=c6/f0/r1/t0", count, full, dispatch_ready, assign_rob_tag); end
      idle_cycle();
      n_cmp++; if (count !== 3'd7 || full !== 1'b1 || assign_rob_tag !== 3'd1 || commit_rob_tag !== 3'd1)
         begin n_err++; $display("FAIL full_refill got=c%0d/f%0b/t%0d/h%0d exp=c7/f1/t1/h1", count, full, assign_rob_tag, commit_rob_tag); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         dispatch_valid = 1'b1;
         dispatch_dest  = REG_ADDR_LEN'(i);
         #1;
         n_cmp++; if (assign_rob_tag !== 3'(i % 7)) begin n_err++; $display("FAIL wrap_tag%0d got=%0d exp=%0d", i, assign_rob_tag, i % 7); end
         @(negedge clk);
         dispatch_valid = 1'b0;
         cdb_valid = 1'b1; cdb_rob_tag = 3'(i % 7); cdb_value = 32'(100 + i);
         idle_cycle();
         n_cmp++; if (commit_valid !== 1'b1 || commit_rob_tag !== 3'(i % 7) || commit_value !== 32'(100 + i))
            begin n_err++; $display("FAIL wrap_commit%0d got=%0b/t%0d/%0d exp=1/t%0d/%0d", i, commit_valid, commit_rob_tag, commit_value, i % 7, 100 + i); end
      end
      idle_cycle();
      n_cmp++; if (empty !== 1'b1 || assign_rob_tag !== 3'd3) begin n_err++; $display("FAIL wrap_end got=e%0b/t%0d exp=e1/t3", empty, assign_rob_tag); end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] exp_same;
`ifdef ROB_CDB_BYPASS_EN
      exp_same = 32'h1234;
`else
      exp_same = 32'h0;
`endif
      do_reset();
      dispatch_n(4);
      @(negedge clk);
      dispatch_valid = 1'b0;
      cdb_valid = 1'b1; cdb_rob_tag = 3'd3; cdb_value = 32'h1234;
      rd1_tag = 3'd3; rd2_tag = 3'd2;
      #1;
      n_cmp++; if (rd1_value !== exp_same) begin n_err++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd1_value, exp_same); end
      n_cmp++; if (rd2_value !== 32'h0) begin n_err++; $display("FAIL bypass_other_tag got=%h exp=0", rd2_value); end
      idle_cycle();
      rd2_tag = 3'd7;
      #1;
      n_cmp++; if (rd1_value !== 32'h1234) begin n_err++; $display("FAIL bypass_next_cycle got=%h exp=1234", rd1_value); end
      n_cmp++; if (rd2_value !== 32'h0) begin n_err++; $display("FAIL read_no_tag got=%h exp=0", rd2_value); end
   endtask

   task automatic test_async_reset();
      do_reset();
      dispatch_n(4);
      @(negedge clk);
      dispatch_valid = 1'b0;
      cdb_valid = 1'b1; cdb_rob_tag = 3'd0; cdb_value = 32'h99;
      idle_cycle();
      rd1_tag = 3'd0;
      #1;
      n_cmp++; if (commit_valid !== 1'b1 || rd1_value !== 32'h99 || count !== 3'd4)
         begin n_err++; $display("FAIL areset_pre got=%0b/%h/c%0d exp=1/99/c4", commit_valid, rd1_value, count); end
      reset = 1'b1;
      #1;
      n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || commit_valid !== 1'b0 || rd1_value !== 32'h0 || dispatch_ready !== 1'b1 || assign_rob_tag !== 3'd0)
         begin n_err++; $display("FAIL areset_immediate got=c%0d/e%0b/v%0b/%h/r%0b/t%0d exp=c0/e1/v0/0/r1/t0",
                                 count, empty, commit_valid, rd1_value, dispatch_ready, assign_rob_tag); end
      #1;
      reset = 1'b0;
      @(negedge clk);
      cdb_valid = 1'b1; cdb_rob_tag = 3'd2; cdb_value = 32'h77;
      rd1_tag = 3'd2;
      idle_cycle();
      n_cmp++; if (rd1_value !== 32'h0 || count !== 3'd0 || commit_valid !== 1'b0)
         begin n_err++; $display("FAIL areset_cdb_ignored got=%h/c%0d/v%0b exp=0/c0/v0", rd1_value, count, commit_valid); end
   endtask

   initial begin
      test_reset();
      test_commit_order();
      test_full();
      test_wrap();
      test_bypass();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
